key_loader: RTL and testbench

KEY_LOADER -- requirements
Module: key_loader

---
 rtl/key_loader.sv | 166 ++++++++++++++++
 tb/tb_key_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/key_loader.sv
// key_loader: serial key loader for a logic-locked core.
// Shifts KEY_W bits (LSB first) into a shadow register and commits them to
// keyinput atomically, so the locked core never sees a partial key. A load
// aborts into FAIL when the gap between accepted bits reaches TIMEOUT.
// Optional feature macro: KEY_LOADER_PARITY_EN adds a trailing even-parity bit
// that must match the key before it is committed.
module key_loader #(
   parameter int KEY_W   = 2,
   parameter int TIMEOUT = 15
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             START,
   input  logic             KEY_SI,
   input  logic             KEY_SI_VALID,
   output logic [KEY_W-1:0] keyinput,
   output logic             KEY_READY,
   output logic             BUSY,
   output logic             ERR
);

   localparam int CNT_W = $clog2(KEY_W + 1);
   localparam int IDL_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
`ifdef KEY_LOADER_PARITY_EN
      S_PARITY = 2'd2,
`endif
      S_FAIL   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [KEY_W-1:0]   shadow_q, shadow_d;
   logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
   logic [IDL_W-1:0]   idle_q, idle_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic               ready_q, ready_d;
   logic               err_q, err_d;

   logic [KEY_W-1:0]   shadow_set;
   logic               last_bit;
   logic               idle_hit;

   // Shadow with the incoming bit placed at bitcnt; feeds both shifting and the final commit.
   always_comb begin
      shadow_set = shadow_q;
      for (int i = 0; i < KEY_W; i++) begin
         if (bitcnt_q == CNT_W'(i)) shadow_set[i] = KEY_SI;
      end
   end

   assign last_bit = (bitcnt_q == CNT_W'(KEY_W - 1));
   // The idle cycle that would bring the gap count up to TIMEOUT aborts the load.
   assign idle_hit = (idle_q == IDL_W'(TIMEOUT - 1));

   // Next-state and output-register logic; committed outputs only change on commit or failure.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      bitcnt_d = bitcnt_q;
      idle_d   = idle_q;
      key_d    = key_q;
      ready_d  = ready_q;
      err_d    = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d  = S_SHIFT;
               shadow_d = '0;
               bitcnt_d = '0;
               idle_d   = '0;
               err_d    = 1'b0;
            end
         end
         S_SHIFT: begin
            if (KEY_SI_VALID) begin
               shadow_d = shadow_set;
               bitcnt_d = bitcnt_q + CNT_W'(1);
               idle_d   = '0;
               if (last_bit) begin
`ifdef KEY_LOADER_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_IDLE;
                  key_d   = shadow_set;
                  ready_d = 1'b1;
`endif
               end
            end else if (idle_hit) begin
               state_d = S_FAIL;
               idle_d  = '0;
               key_d   = '0;
               ready_d = 1'b0;
               err_d   = 1'b1;
            end else begin
               idle_d = idle_q + IDL_W'(1);
            end
         end
`ifdef KEY_LOADER_PARITY_EN
         S_PARITY: begin
            if (KEY_SI_VALID) begin
               idle_d = '0;
               // Even parity: the extra bit equals the XOR of all key bits.
               if (KEY_SI == ^shadow_q) begin
                  state_d = S_IDLE;
                  key_d   = shadow_q;
                  ready_d = 1'b1;
               end else begin
                  state_d = S_FAIL;
                  key_d   = '0;
                  ready_d = 1'b0;
                  err_d   = 1'b1;
               end
            end else if (idle_hit) begin
               state_d = S_FAIL;
               idle_d  = '0;
               key_d   = '0;
               ready_d = 1'b0;
               err_d   = 1'b1;
            end else begin
               idle_d = idle_q + IDL_W'(1);
            end
         end
`endif
         S_FAIL: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything including the shadow key.
   always_ff @(posedge CK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         shadow_q <= '0;
         bitcnt_q <= '0;
         idle_q   <= '0;
         key_q    <= '0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         bitcnt_q <= bitcnt_d;
         idle_q   <= idle_d;
         key_q    <= key_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
      end
   end

   assign keyinput  = key_q;
   assign KEY_READY = ready_q;
`ifdef KEY_LOADER_PARITY_EN
   assign BUSY      = (state_q == S_SHIFT) || (state_q == S_PARITY);
`else
   assign BUSY      = (state_q == S_SHIFT);
`endif
   assign ERR       = err_q;

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader: directed scenarios followed by random
// traffic, all compared each cycle against a transaction-level reference model.
module tb_key_loader;

   localparam int KEY_W   = 2;
   localparam int TIMEOUT = 15;
`ifdef KEY_LOADER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic             CK;
   logic             RST;
   logic             START;
   logic             KEY_SI;
   logic             KEY_SI_VALID;
   logic [KEY_W-1:0] keyinput;
   logic             KEY_READY;
   logic             BUSY;
   logic             ERR;

   key_loader #(.KEY_W(KEY_W), .TIMEOUT(TIMEOUT)) dut (
      .CK          (CK),
      .RST         (RST),
      .START       (START),
      .KEY_SI      (KEY_SI),
      .KEY_SI_VALID(KEY_SI_VALID),
      .keyinput    (keyinput),
      .KEY_READY   (KEY_READY),
      .BUSY        (BUSY),
      .ERR         (ERR)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: a load is "in progress" collecting a list of bits;
   // after a failure there is one dead cycle before requests are heard again.
   bit               loading;
   bit               failing;
   bit               bits[$];
   int               gap;
   logic [KEY_W-1:0] m_key;
   logic             m_ready;
   logic             m_err;

   task automatic model_fail();
      loading = 0;
      failing = 1;
      m_key   = '0;
      m_ready = 1'b0;
      m_err   = 1'b1;
   endtask

   task automatic model_step(input bit r, input bit st, input bit v, input bit s);
      logic [KEY_W-1:0] k;
      bit               p;
      if (r) begin
         loading = 0; failing = 0; bits.delete(); gap = 0;
         m_key = '0; m_ready = 1'b0; m_err = 1'b0;
         return;
      end
      if (failing) begin
         failing = 0;
         return;
      end
      if (!loading) begin
         if (st) begin
            loading = 1; bits.delete(); gap = 0; m_err = 1'b0;
         end
         return;
      end
      if (v) begin
         gap = 0;
         bits.push_back(s);
         if (bits.size() == KEY_W + PAR) begin
            p = 0;
            for (int i = 0; i < KEY_W; i++) begin
               k[i] = bits[i];
               p    = p ^ bits[i];
            end
            if (PAR == 1 && bits[KEY_W] != p) begin
               model_fail();
            end else begin
               loading = 0;
               m_key   = k;
               m_ready = 1'b1;
            end
         end
      end else begin
         gap++;
         if (gap == TIMEOUT) model_fail();
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance DUT and model together, compare all outputs.
   task automatic step(input bit r, input bit st, input bit v, input bit s);
      RST = r; START = st; KEY_SI_VALID = v; KEY_SI = s;
      @(posedge CK);
      model_step(r, st, v, s);
      cyc++;
      #1;
      chk("keyinput",  32'(keyinput),  32'(m_key));
      chk("KEY_READY", 32'(KEY_READY), 32'(m_ready));
      chk("BUSY",      32'(BUSY),      32'(loading));
      chk("ERR",       32'(ERR),       32'(m_err));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   int pv;

   initial begin
      RST = 1'b1; START = 1'b0; KEY_SI = 1'b0; KEY_SI_VALID = 1'b0;
      loading = 0; failing = 0; gap = 0;
      m_key = '0; m_ready = 1'b0; m_err = 1'b0;

      // Reset state
      step(1, 0, 0, 0);
      step(1, 1, 1, 1);
      chk("reset_key", 32'(keyinput), 32'd0);
      chk("reset_busy", 32'(BUSY), 32'd0);

      // Basic load of bits 1,0 -> 2'b01
      step(0, 1, 0, 0);
      step(0, 0, 1, 1);
      step(0, 0, 1, 0);
      if (PAR == 1) step(0, 0, 1, 1);
      chk("load01_key", 32'(keyinput), 32'd1);
      chk("load01_ready", 32'(KEY_READY), 32'd1);
      idle(2);

      // Valid in idle is ignored
      step(0, 0, 1, 1);
      step(0, 0, 1, 0);

      // Timeout: one bit then TIMEOUT idle cycles, old key held until abort
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      idle(TIMEOUT);
      chk("timeout_key", 32'(keyinput), 32'd0);
      chk("timeout_err", 32'(ERR), 32'd1);
      // FAIL cycle ignores START and valid
      step(0, 1, 1, 1);
      idle(2);

      // Reset in the middle of a load, then a clean 0,0 load
      step(0, 1, 0, 0);
      step(0, 0, 1, 1);
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      if (PAR == 1) step(0, 0, 1, 0);
      chk("rst_reload_ready", 32'(KEY_READY), 32'd1);
      idle(1);

      // START with valid at load start; START repeated while busy
      step(0, 1, 1, 1);
      step(0, 1, 1, 0);
      step(0, 1, 0, 0);
      step(0, 1, 1, 1);
      if (PAR == 1) step(0, 1, 1, 1);
      chk("restart_key", 32'(keyinput), 32'd2);
      idle(1);

      // Parity good then bad (only meaningful with parity enabled)
      step(0, 1, 0, 0);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      if (PAR == 1) step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      if (PAR == 1) step(0, 0, 1, 1);
      idle(3);

      // Random traffic with phases of dense, medium and sparse valid
      for (int blk = 0; blk < 12; blk++) begin
         case (blk % 3)
            0: pv = 90;
            1: pv = 50;
            default: pv = 4;
         endcase
         for (int c = 0; c < 60; c++) begin
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 99) < pv),
                 $urandom_range(0, 1) == 1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
